// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions: instruction constants, PC-select
// encodings and the {pc, instr} bundle carried through the fetch queue.
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [1:0] PCSRC_PLUS4  = 2'b00;
  localparam logic [1:0] PCSRC_TARGET = 2'b01;
  localparam logic [1:0] PCSRC_JALR   = 2'b10;

  localparam int FETCH_MAX_OUTST = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // 11 behaves like a branch/JAL target
  function automatic logic [31:0] redirect_target(
    input logic [1:0]  src,
    input logic [31:0] tgt,
    input logic [31:0] alu
  );
    return (src == PCSRC_JALR) ? (alu & ~32'd1) : tgt;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Two-entry synchronous FIFO of fetched {pc, instr} pairs.
// Push and pop may coincide even when full; clear wins over both.
module fetch_queue
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         push,
  input  logic         pop,
  input  fetch_entry_t din,
  output fetch_entry_t head,
  output logic [1:0]   count
);

  fetch_entry_t mem [2];
  logic         rd_ptr;
  logic         wr_ptr;
  logic         do_push;
  logic         do_pop;

  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && ((count != 2'd2) || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else if (clear) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + 2'(do_push) - 2'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch with up to two requests in flight, a response
// queue, stale-response dropping after redirects, and the IF/ID register.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic [1:0]  PCSrcE,
  input  logic [31:0] PCTargetE,
  input  logic [31:0] ALUResultE,
  output logic        IMemReqValid,
  output logic [31:0] IMemReqAddr,
  input  logic        IMemReqReady,
  input  logic        IMemRespValid,
  input  logic [31:0] IMemRespData,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD
);

  logic [31:0]  pcf;
  logic [31:0]  pcr;
  logic [1:0]   outst;
  logic [1:0]   drop;
  logic [1:0]   qcount;
  logic [31:0]  target;
  logic         redirect;
  logic         req_fire;
  logic         resp_in;
  logic         accept;
  logic         bypass;
  logic         push;
  logic         pop;
  fetch_entry_t q_head;
  fetch_entry_t resp_entry;

  assign redirect = (PCSrcE != PCSRC_PLUS4);
  assign target   = redirect_target(PCSrcE, PCTargetE, ALUResultE);

  // queued entries hold credits too, so the queue can never overflow
  assign IMemReqValid = !rst && !StallF && !redirect &&
                        (({1'b0, outst} + {1'b0, qcount}) < 3'(FETCH_MAX_OUTST));
  assign IMemReqAddr  = pcf;
  assign req_fire     = IMemReqValid && IMemReqReady;

  // a response with nothing outstanding belongs to a pre-reset request
  assign resp_in    = IMemRespValid && (outst != 2'd0);
  assign accept     = resp_in && !redirect && (drop == 2'd0);
  assign resp_entry = '{pc: pcr, instr: IMemRespData};

  assign pop    = !redirect && !FlushD && !StallD && (qcount != 2'd0);
  assign bypass = accept && !FlushD && !StallD && (qcount == 2'd0);
  assign push   = accept && !bypass;

  fetch_queue u_queue (
    .clk   (clk),
    .rst   (rst),
    .clear (redirect),
    .push  (push),
    .pop   (pop),
    .din   (resp_entry),
    .head  (q_head),
    .count (qcount)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcf   <= RESET_PC;
      pcr   <= RESET_PC;
      outst <= 2'd0;
      drop  <= 2'd0;
    end else begin
      outst <= outst + 2'(req_fire) - 2'(resp_in);
      if (redirect) begin
        pcf  <= target;
        pcr  <= target;
        drop <= outst - 2'(resp_in);
      end else begin
        if (req_fire) pcf <= pcf + 32'd4;
        if (accept) pcr <= pcr + 32'd4;
        if (resp_in && (drop != 2'd0)) drop <= drop - 2'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      InstrD   <= NOP_INSTR;
      PCD      <= 32'd0;
      PCPlus4D <= 32'd0;
      ValidD   <= 1'b0;
    end else if (FlushD || redirect) begin
      InstrD <= NOP_INSTR;
      ValidD <= 1'b0;
    end else if (!StallD) begin
      if (pop) begin
        InstrD   <= q_head.instr;
        PCD      <= q_head.pc;
        PCPlus4D <= q_head.pc + 32'd4;
        ValidD   <= 1'b1;
      end else if (bypass) begin
        InstrD   <= resp_entry.instr;
        PCD      <= resp_entry.pc;
        PCPlus4D <= resp_entry.pc + 32'd4;
        ValidD   <= 1'b1;
      end else begin
        InstrD <= NOP_INSTR;
        ValidD <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: in-order memory with in-flight list,
// reference model built on request/stale lists and a delivery queue.
module tb_fetch_unit;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        StallF, StallD, FlushD;
  logic [1:0]  PCSrcE;
  logic [31:0] PCTargetE, ALUResultE;
  logic        IMemReqValid;
  logic [31:0] IMemReqAddr;
  logic        IMemReqReady;
  logic        IMemRespValid;
  logic [31:0] IMemRespData;
  logic [31:0] InstrD, PCD, PCPlus4D;
  logic        ValidD;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .rst          (rst),
    .StallF       (StallF),
    .StallD       (StallD),
    .FlushD       (FlushD),
    .PCSrcE       (PCSrcE),
    .PCTargetE    (PCTargetE),
    .ALUResultE   (ALUResultE),
    .IMemReqValid (IMemReqValid),
    .IMemReqAddr  (IMemReqAddr),
    .IMemReqReady (IMemReqReady),
    .IMemRespValid(IMemRespValid),
    .IMemRespData (IMemRespData),
    .InstrD       (InstrD),
    .PCD          (PCD),
    .PCPlus4D     (PCPlus4D),
    .ValidD       (ValidD)
  );

  typedef struct {
    logic [31:0] addr;
    bit          stale;
  } fl_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  fl_t         fl[$];
  ent_t        bq[$];
  logic [31:0] m_pcf, m_instr, m_pc, m_pc4;
  logic        m_valid;

  function automatic logic [31:0] word(input logic [31:0] a);
    return {a[15:0] ^ a[31:16], ~a[15:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset;
    fl.delete();
    bq.delete();
    m_pcf   = 32'h0;
    m_instr = NOP_INSTR;
    m_pc    = 32'h0;
    m_pc4   = 32'h0;
    m_valid = 1'b0;
  endtask

  task automatic check_regs;
    chk("ValidD", ValidD, m_valid);
    chk("InstrD", InstrD, m_instr);
    chk("PCD", PCD, m_pc);
    chk("PCPlus4D", PCPlus4D, m_pc4);
  endtask

  // one cycle: entered at a negedge, returns at the next negedge
  task automatic step(input bit sf, input bit sd, input bit fd,
                      input logic [1:0] src, input logic [31:0] tgt,
                      input logic [31:0] alu, input bit rdy, input bit rsp);
    bit          red, expv, fire, acc, rv;
    logic [31:0] t, rw;
    fl_t         e;
    ent_t        h;
    check_regs();
    red  = (src != 2'b00);
    t    = (src == 2'b10) ? {alu[31:1], 1'b0} : tgt;
    expv = !sf && !red && ((fl.size() + bq.size()) < 2);
    rv   = rsp && (fl.size() > 0);
    e    = '{addr: 32'h0, stale: 1'b0};
    rw   = $urandom;
    if (rv) begin
      e  = fl.pop_front();
      rw = word(e.addr);
    end
    StallF        = sf;
    StallD        = sd;
    FlushD        = fd;
    PCSrcE        = src;
    PCTargetE     = tgt;
    ALUResultE    = alu;
    IMemReqReady  = rdy;
    IMemRespValid = rv;
    IMemRespData  = rw;
    #1;
    chk("IMemReqValid", IMemReqValid, expv);
    if (expv) chk("IMemReqAddr", IMemReqAddr, m_pcf);
    fire = expv && rdy;
    acc  = rv && !e.stale && !red;
    if (fd || red) begin
      m_instr = NOP_INSTR;
      m_valid = 1'b0;
    end else if (!sd) begin
      if (bq.size() > 0) begin
        h       = bq.pop_front();
        m_instr = h.instr;
        m_pc    = h.pc;
        m_pc4   = h.pc + 32'd4;
        m_valid = 1'b1;
      end else if (acc) begin
        m_instr = rw;
        m_pc    = e.addr;
        m_pc4   = e.addr + 32'd4;
        m_valid = 1'b1;
        acc     = 1'b0;
      end else begin
        m_instr = NOP_INSTR;
        m_valid = 1'b0;
      end
    end
    if (acc) bq.push_back('{pc: e.addr, instr: rw});
    if (red) begin
      bq.delete();
      foreach (fl[i]) fl[i].stale = 1'b1;
      m_pcf = t;
    end else if (fire) begin
      fl.push_back('{addr: m_pcf, stale: 1'b0});
      m_pcf = m_pcf + 32'd4;
    end
    @(negedge clk);
  endtask

  task automatic run(input bit sd, input int n);
    for (int i = 0; i < n; i++) step(0, sd, 0, 2'b00, 0, 0, 1, 1);
  endtask

  initial begin
    bit found;
    rst = 1'b1;
    StallF = 0; StallD = 0; FlushD = 0; PCSrcE = 2'b00;
    PCTargetE = 0; ALUResultE = 0;
    IMemReqReady = 0; IMemRespValid = 0; IMemRespData = 0;
    repeat (3) @(negedge clk);
    chk("rst_valid", ValidD, 1'b0);
    chk("rst_instr", InstrD, 32'h0000_0013);
    chk("rst_pcd", PCD, 32'h0);
    chk("rst_pc4", PCPlus4D, 32'h0);
    chk("rst_req", IMemReqValid, 1'b0);
    model_reset();
    rst = 1'b0;

    run(0, 2);
    chk("stream_pc0", PCD, 32'h0);
    chk("stream_in0", InstrD, 32'h0000_FFFF);
    chk("stream_v0", ValidD, 1'b1);
    run(0, 1);
    chk("stream_pc4", PCD, 32'h4);
    chk("stream_in4", InstrD, 32'h0004_FFFB);
    run(0, 1);
    chk("stream_pc8", PCD, 32'h8);
    chk("stream_p48", PCPlus4D, 32'hC);

    run(1, 3);
    chk("stall_req", IMemReqValid, 1'b0);
    chk("stall_hold", PCD, 32'h8);
    run(0, 1);
    chk("unstall_c", PCD, 32'hC);
    run(0, 1);
    chk("unstall_10", PCD, 32'h10);
    run(0, 1);
    chk("unstall_14", PCD, 32'h14);

    step(0, 0, 0, 2'b00, 0, 0, 1, 0);
    step(0, 0, 0, 2'b01, 32'h100, 0, 1, 0);
    chk("redir_addr", IMemReqAddr, 32'h100);
    run(0, 3);
    chk("redir_pcd", PCD, 32'h100);
    chk("redir_v", ValidD, 1'b1);

    step(0, 0, 0, 2'b10, 0, 32'h205, 1, 1);
    chk("jalr_addr", IMemReqAddr, 32'h204);
    run(0, 3);
    step(0, 1, 1, 2'b00, 0, 0, 1, 1);
    chk("flush_v", ValidD, 1'b0);
    chk("flush_in", InstrD, 32'h0000_0013);

    step(0, 0, 0, 2'b01, 32'hFFFF_FFFC, 0, 1, 1);
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      if (ValidD && PCD == 32'hFFFF_FFFC) found = 1'b1;
      else run(0, 1);
    end
    chk("wrap_seen", 32'(found), 32'h1);
    if (found) chk("wrap_pc4", PCPlus4D, 32'h0);
    run(0, 1);
    chk("wrap_next", PCD, 32'h0);

    for (int i = 0; i < 4; i++) step(0, 0, 0, 2'b00, 0, 0, 1, 0);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", ValidD, 1'b0);
    chk("arst_instr", InstrD, 32'h0000_0013);
    chk("arst_pcd", PCD, 32'h0);
    chk("arst_req", IMemReqValid, 1'b0);
    model_reset();
    StallF = 1; PCSrcE = 2'b00; FlushD = 0; StallD = 0;
    IMemReqReady = 0; IMemRespValid = 0;
    repeat (2) @(negedge clk);
    chk("arst_hold", IMemReqValid, 1'b0);
    rst = 1'b0;
    StallF = 0;
    #1;
    chk("restart_v", IMemReqValid, 1'b1);
    chk("restart_a", IMemReqAddr, 32'h0);
    @(negedge clk);

    for (int i = 0; i < 4000; i++) begin
      bit          sf, sd, fd, rdy, rsp;
      logic [1:0]  src;
      logic [31:0] tgt;
      sf  = ($urandom_range(0, 99) < 15);
      sd  = ($urandom_range(0, 99) < 20);
      fd  = ($urandom_range(0, 99) < 5);
      src = ($urandom_range(0, 99) < 6) ? 2'($urandom_range(1, 3)) : 2'b00;
      tgt = ($urandom_range(0, 9) == 0) ? 32'($urandom) : ($urandom & 32'hFFFF_FFFC);
      rdy = ($urandom_range(0, 99) < 70);
      rsp = ($urandom_range(0, 99) < 60);
      step(sf, sd, fd, src, tgt, 32'($urandom), rdy, rsp);
    end
    check_regs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
